// File: rtl/idli_sqi_sram.sv
// idli_sqi_sram: responder end of the idli SQI memory interface. A quad-SPI
// SRAM model (23LC1024 sequential quad mode) that decodes command, address
// and data nibbles and drives read data back, one nibble per i_clk.
//
// Optional feature macro: IDLI_SQI_SRAM_MODE_REG_EN adds the 8-bit mode
// register with WRMR (0x01), RDMR (0x05), byte and page modes. Without it the
// device is always sequential and 0x01/0x05 are ignored like any unknown
// command.
//
// Ports:
//   i_clk       clock; bus synchronous to it
//   i_rst_n     synchronous active-low reset (memory array is not cleared)
//   i_sqi_cs_n  chip select, active low
//   i_sqi_sio   nibble from controller, sampled while i_sqi_cs_n = 0
//   o_sqi_sio   registered nibble to controller, valid when o_sqi_mode = OUT
//   o_sqi_mode  1 (OUT) when this block drives the bus, 0 (IN) otherwise
module idli_sqi_sram #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sqi_cs_n,
    input  logic [3:0] i_sqi_sio,
    output logic [3:0] o_sqi_sio,
    output logic       o_sqi_mode
);

    localparam logic SQI_MODE_IN  = 1'b0;
    localparam logic SQI_MODE_OUT = 1'b1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StDummy, StRd, StWr, StIgnore, StWrmr
    } state_t;

    logic [7:0]        r_mem [DEPTH];
    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx, w_addr_inc, w_rd_addr;
    logic [7:0]        r_cmd, w_cmd_nx, w_rd_byte, w_wdata;
    logic [2:0]        r_cnt, w_cnt_nx;
    logic              r_half, w_half_nx;   // 1: next nibble is the low half
    logic [3:0]        r_wr_hi, w_wr_hi_nx;
    logic [3:0]        r_sio, w_sio_nx;
    logic              r_mode, w_mode_nx;
    logic              w_we;
    logic              w_byte_mode, w_page_mode;

`ifdef IDLI_SQI_SRAM_MODE_REG_EN
    logic [7:0] r_mreg, w_mreg_nx;
    logic       r_rdmr, w_rdmr_nx;
    assign w_byte_mode = (r_mreg[7:6] == 2'b00);
    assign w_page_mode = (r_mreg[7:6] == 2'b10);
`else
    assign w_byte_mode = 1'b0;
    assign w_page_mode = 1'b0;
`endif

    assign w_addr_inc = w_page_mode ? {r_addr[ADDR_W-1:5], r_addr[4:0] + 5'd1}
                                    : r_addr + ADDR_ONE;
    // In RD with the low nibble already sent, look ahead to the next byte.
    assign w_rd_addr  = (r_state == StRd && !r_half) ? w_addr_inc : r_addr;
    assign w_rd_byte  = r_mem[w_rd_addr];

    assign o_sqi_sio  = r_sio;
    assign o_sqi_mode = r_mode;

    always_comb begin
        w_state_nx  = r_state;
        w_addr_nx   = r_addr;
        w_cmd_nx    = r_cmd;
        w_cnt_nx    = r_cnt;
        w_half_nx   = r_half;
        w_wr_hi_nx  = r_wr_hi;
        w_sio_nx    = r_sio;
        w_mode_nx   = r_mode;
        w_we        = 1'b0;
        w_wdata     = {r_wr_hi, i_sqi_sio};
`ifdef IDLI_SQI_SRAM_MODE_REG_EN
        w_mreg_nx   = r_mreg;
        w_rdmr_nx   = r_rdmr;
`endif
        if (i_sqi_cs_n) begin
            w_state_nx = StIdle;
            w_mode_nx  = SQI_MODE_IN;
            w_cnt_nx   = 3'd0;
            w_half_nx  = 1'b0;
`ifdef IDLI_SQI_SRAM_MODE_REG_EN
            w_rdmr_nx  = 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    w_cmd_nx   = {i_sqi_sio, 4'h0};
                    w_state_nx = StCmd;
                end
                StCmd: begin
                    w_cmd_nx = {r_cmd[7:4], i_sqi_sio};
                    w_cnt_nx = 3'd0;
                    case ({r_cmd[7:4], i_sqi_sio})
                        8'h02, 8'h03: w_state_nx = StAddr;
`ifdef IDLI_SQI_SRAM_MODE_REG_EN
                        8'h01:        w_state_nx = StWrmr;
                        8'h05: begin
                            w_state_nx = StDummy;
                            w_rdmr_nx  = 1'b1;
                        end
`endif
                        default:      w_state_nx = StIgnore;
                    endcase
                end
                StAddr: begin
                    // Shifting into ADDR_W bits drops the unused upper address bits.
                    w_addr_nx = {r_addr[ADDR_W-5:0], i_sqi_sio};
                    w_cnt_nx  = r_cnt + 3'd1;
                    if (r_cnt == 3'd5) begin
                        w_cnt_nx   = 3'd0;
                        w_half_nx  = 1'b0;
                        w_state_nx = (r_cmd == 8'h03) ? StDummy : StWr;
                    end
                end
                StDummy: begin
                    w_cnt_nx = r_cnt + 3'd1;
                    if (r_cnt == 3'd1) begin
                        w_mode_nx  = SQI_MODE_OUT;
                        w_sio_nx   = w_rd_byte[7:4];
                        w_half_nx  = 1'b1;
                        w_state_nx = StRd;
`ifdef IDLI_SQI_SRAM_MODE_REG_EN
                        if (r_rdmr) w_sio_nx = r_mreg[7:4];
`endif
                    end
                end
                StRd: begin
                    w_half_nx = ~r_half;
                    if (r_half) begin
                        w_sio_nx = w_rd_byte[3:0];
                    end else if (w_byte_mode) begin
                        w_mode_nx  = SQI_MODE_IN;
                        w_state_nx = StIgnore;
                    end else begin
                        w_addr_nx = w_addr_inc;
                        w_sio_nx  = w_rd_byte[7:4];
                    end
`ifdef IDLI_SQI_SRAM_MODE_REG_EN
                    if (r_rdmr) begin
                        w_mode_nx  = SQI_MODE_OUT;
                        w_state_nx = StRd;
                        w_addr_nx  = r_addr;
                        w_sio_nx   = r_half ? r_mreg[3:0] : r_mreg[7:4];
                    end
`endif
                end
                StWr: begin
                    w_half_nx = ~r_half;
                    if (!r_half) begin
                        w_wr_hi_nx = i_sqi_sio;
                    end else begin
                        w_we      = i_rst_n;
                        w_addr_nx = w_addr_inc;
                        if (w_byte_mode) w_state_nx = StIgnore;
                    end
                end
`ifdef IDLI_SQI_SRAM_MODE_REG_EN
                StWrmr: begin
                    if (r_cnt == 3'd0) begin
                        w_wr_hi_nx = i_sqi_sio;
                        w_cnt_nx   = 3'd1;
                    end else begin
                        w_mreg_nx  = {r_wr_hi, i_sqi_sio};
                        w_state_nx = StIgnore;
                    end
                end
`endif
                default: w_state_nx = StIgnore;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_cmd   <= 8'h00;
            r_cnt   <= 3'd0;
            r_half  <= 1'b0;
            r_wr_hi <= 4'h0;
            r_sio   <= 4'h0;
            r_mode  <= SQI_MODE_IN;
`ifdef IDLI_SQI_SRAM_MODE_REG_EN
            r_mreg  <= 8'h40;
            r_rdmr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_addr  <= w_addr_nx;
            r_cmd   <= w_cmd_nx;
            r_cnt   <= w_cnt_nx;
            r_half  <= w_half_nx;
            r_wr_hi <= w_wr_hi_nx;
            r_sio   <= w_sio_nx;
            r_mode  <= w_mode_nx;
`ifdef IDLI_SQI_SRAM_MODE_REG_EN
            r_mreg  <= w_mreg_nx;
            r_rdmr  <= w_rdmr_nx;
`endif
        end
    end

    // Array has no reset; contents are unknown until written.
    always_ff @(posedge i_clk) begin
        if (w_we) r_mem[r_addr] <= w_wdata;
    end

endmodule

// File: tb/tb_idli_sqi_sram.sv
// Bench for idli_sqi_sram (default build, mode register disabled). A byte-level
// memory model predicts every output nibble; directed transactions pin the
// model with literal values, then random transactions exercise it further.
module tb_idli_sqi_sram;

    localparam int ADDR_W = 17;
    localparam int DEPTH  = 1 << ADDR_W;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_sqi_cs_n = 1'b1;
    logic [3:0] i_sqi_sio = 4'h0;
    logic [3:0] o_sqi_sio;
    logic       o_sqi_mode;

    idli_sqi_sram #(.ADDR_W(ADDR_W)) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_sqi_cs_n (i_sqi_cs_n),
        .i_sqi_sio  (i_sqi_sio),
        .o_sqi_sio  (o_sqi_sio),
        .o_sqi_mode (o_sqi_mode)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic       exp_chk = 1'b0;
    logic       exp_mode = 1'b0;
    logic       exp_sio_chk = 1'b0;
    logic [3:0] exp_sio = 4'h0;

    logic [7:0] mdl [int];       // byte model of the array; absent = unknown
    logic [7:0] wq [$];          // bytes for the next write
    logic [7:0] rq [$];          // bytes captured by the last read

    function automatic void check(input string name, input logic [7:0] got,
                                  input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    // Single compare process against the model's per-cycle prediction.
    always @(negedge clk) begin
        if (exp_chk) begin
            check("mode", {7'd0, o_sqi_mode}, {7'd0, exp_mode});
            if (exp_sio_chk) check("sio", {4'd0, o_sqi_sio}, {4'd0, exp_sio});
        end
    end

    task automatic cyc(input logic csn, input logic [3:0] nib, input logic rstn,
                       input logic emode, input logic eschk, input logic [3:0] esio);
        i_sqi_cs_n = csn;
        i_sqi_sio  = nib;
        i_rst_n    = rstn;
        @(posedge clk);
        exp_mode    = emode;
        exp_sio_chk = eschk;
        exp_sio     = esio;
        exp_chk     = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_in(input logic [3:0] nib);
        cyc(1'b0, nib, 1'b1, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic idle1();
        cyc(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_in(b[7:4]);
        send_in(b[3:0]);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        send_byte(cmd);
        for (int i = 5; i >= 0; i--) send_in(a[i*4 +: 4]);
    endtask

    task automatic do_write(input logic [23:0] a, input bit partial,
                            input logic [3:0] pnib);
        int ma;
        ma = int'(a[ADDR_W-1:0]);
        send_hdr(8'h02, a);
        foreach (wq[i]) begin
            send_byte(wq[i]);
            mdl[ma] = wq[i];
            ma = (ma + 1) % DEPTH;
        end
        if (partial) send_in(pnib);
        idle1();
    endtask

    task automatic do_read(input logic [23:0] a, input int nb);
        int ma;
        logic [7:0] b;
        logic known;
        logic [3:0] hi;
        ma = int'(a[ADDR_W-1:0]);
        rq.delete();
        send_hdr(8'h03, a);
        send_in(4'($urandom_range(0, 15)));
        for (int k = 0; k < nb; k++) begin
            known = mdl.exists(ma);
            b = known ? mdl[ma] : 8'h00;
            cyc(1'b0, 4'($urandom_range(0, 15)), 1'b1, 1'b1, known, b[7:4]);
            hi = o_sqi_sio;
            cyc(1'b0, 4'($urandom_range(0, 15)), 1'b1, 1'b1, known, b[3:0]);
            rq.push_back({hi, o_sqi_sio});
            ma = (ma + 1) % DEPTH;
        end
        idle1();
    endtask

    task automatic do_ignore(input logic [7:0] cmd, input int n);
        send_byte(cmd);
        for (int i = 0; i < n; i++) send_in(4'($urandom_range(0, 15)));
        idle1();
    endtask

    function automatic logic [23:0] rand_addr();
        logic [6:0]  top;
        logic [16:0] low;
        top = 7'($urandom_range(0, 127));
        if ($urandom_range(0, 1) == 0) low = 17'($urandom_range(0, 63));
        else low = 17'(DEPTH - 1 - int'($urandom_range(0, 7)));
        return {top, low};
    endfunction

    initial begin
        logic [7:0] cmd;
        // Reset with cs_n high: outputs at reset values.
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0);
        cyc(1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0);

        // Basic write then read.
        wq = '{8'hA5, 8'h3C};
        do_write(24'h000010, 1'b0, 4'h0);
        do_read(24'h000010, 2);
        check("rd_10", rq[0], 8'hA5);
        check("rd_11", rq[1], 8'h3C);

        // Address wrap at the top of the array.
        wq = '{8'h11, 8'h22};
        do_write(24'(DEPTH - 1), 1'b0, 4'h0);
        do_read(24'h000000, 1);
        check("wrap_rd_0", rq[0], 8'h22);
        do_read(24'(DEPTH - 1), 2);
        check("wrap_rd_top", rq[0], 8'h11);
        check("wrap_rd_top1", rq[1], 8'h22);

        // Partial byte is discarded on cs_n release.
        wq = '{8'h00};
        do_write(24'h000020, 1'b0, 4'h0);
        wq.delete();
        do_write(24'h000020, 1'b1, 4'hF);
        do_read(24'h000020, 1);
        check("partial", rq[0], 8'h00);

        // Unknown command is ignored.
        do_ignore(8'hFF, 10);
        do_ignore(8'h01, 4);
        do_ignore(8'h05, 6);
        do_read(24'h000010, 1);
        check("after_ignore", rq[0], 8'hA5);

        // Reset in the middle of a read.
        send_hdr(8'h03, 24'h000010);
        send_in(4'h0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'hA);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0);
        idle1();
        do_read(24'h000010, 1);
        check("after_reset", rq[0], 8'hA5);

        // Randomised transactions against the model.
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    wq.delete();
                    for (int i = 0; i < int'($urandom_range(0, 4)); i++)
                        wq.push_back(8'($urandom_range(0, 255)));
                    do_write(rand_addr(), $urandom_range(0, 1) == 1,
                             4'($urandom_range(0, 15)));
                end
                2: do_read(rand_addr(), int'($urandom_range(1, 5)));
                default: begin
                    cmd = 8'($urandom_range(0, 255));
                    if (cmd == 8'h02 || cmd == 8'h03) cmd = 8'hFF;
                    do_ignore(cmd, int'($urandom_range(0, 12)));
                end
            endcase
        end

        exp_chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
